// File: rtl/fma_issue_unit.sv
// fma_issue_unit: issue/retire stage around a fused multiply-add datapath.
// Accepts one R4-type FP instruction at a time and applies the sign flips for
// FMADD/FMSUB/FNMSUB/FNMADD. It pulses fma_valid for one cycle, waits for
// fma_done, then holds the result for writeback under a valid/ready handshake.
// A watchdog substitutes QNAN if the completion never arrives.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   in_valid/in_ready             instruction handshake (ready only in IDLE)
//   in_op, in_rs1..3, in_rd_idx   decoded instruction
//   flush                         abort the current op
//   fma_valid, fma_rs1..3         start pulse and sign-adjusted operands
//   fma_done, fma_rd              datapath completion and result
//   out_valid/out_ready           writeback handshake
//   out_result, out_rd_idx        held result and destination index
//   busy                          state != IDLE
//   err                           sticky: timeout or spurious fma_done
module fma_issue_unit #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      TIMEOUT = 16,
  parameter logic [WIDTH-1:0] QNAN    = 'h7FC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_rs3,
  input  logic [4:0]       in_rd_idx,
  input  logic             flush,
  output logic             fma_valid,
  output logic [WIDTH-1:0] fma_rs1,
  output logic [WIDTH-1:0] fma_rs2,
  output logic [WIDTH-1:0] fma_rs3,
  input  logic             fma_done,
  input  logic [WIDTH-1:0] fma_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd_idx,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StDrain} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      fma_valid  <= 1'b0;
      fma_rs1    <= '0;
      fma_rs2    <= '0;
      fma_rs3    <= '0;
      out_result <= '0;
      out_rd_idx <= '0;
      err        <= 1'b0;
    end else begin
      fma_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (fma_done) err <= 1'b1;
          if (in_valid) begin
            // op[1] negates the product (flip rs1), op[0] negates the addend (flip rs3)
            fma_rs1    <= {in_rs1[WIDTH-1] ^ in_op[1], in_rs1[WIDTH-2:0]};
            fma_rs2    <= in_rs2;
            fma_rs3    <= {in_rs3[WIDTH-1] ^ in_op[0], in_rs3[WIDTH-2:0]};
            out_rd_idx <= in_rd_idx;
            fma_valid  <= 1'b1;
            cnt        <= '0;
            state      <= StWait;
          end
        end
        StWait: begin
          if (flush) begin
            // The datapath is still running; DRAIN swallows its completion.
            cnt   <= '0;
            state <= StDrain;
          end else if (fma_done) begin
            out_result <= fma_rd;
            state      <= StHold;
          end else if (cnt == CntLast) begin
            out_result <= QNAN;
            err        <= 1'b1;
            state      <= StHold;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHold: begin
          if (fma_done) err <= 1'b1;
          if (flush || out_ready) state <= StIdle;
        end
        StDrain: begin
          if (fma_done) begin
            state <= StIdle;
          end else if (cnt == CntLast) begin
            err   <= 1'b1;
            state <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign out_valid = (state == StHold);
  assign busy      = (state != StIdle);
  assign in_ready  = (state == StIdle) && !rst;

endmodule

// File: tb/tb_fma_issue_unit.sv
module tb_fma_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2, in_rs3;
  logic [4:0]  in_rd_idx;
  logic        flush;
  logic        fma_valid;
  logic [31:0] fma_rs1, fma_rs2, fma_rs3;
  logic        fma_done;
  logic [31:0] fma_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd_idx;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  logic [36:0] exp_out_q[$];  // {rd_idx, result}
  logic [95:0] exp_fma_q[$];  // {rs1, rs2, rs3}
  logic        prev_fv = 1'b0;

  fma_issue_unit #(.WIDTH(32), .TIMEOUT(16), .QNAN(32'h7FC00000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_rd_idx(in_rd_idx),
    .flush(flush), .fma_valid(fma_valid), .fma_rs1(fma_rs1), .fma_rs2(fma_rs2),
    .fma_rs3(fma_rs3), .fma_done(fma_done), .fma_rd(fma_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd_idx(out_rd_idx),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every writeback handshake must match the next expected result.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_out_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_out_q.pop_front();
        chk("out_result", out_result, e[31:0]);
        chk("out_rd_idx", 32'(out_rd_idx), 32'(e[36:32]));
      end
    end
  end

  // Datapath-side monitor: each start pulse is single-cycle and carries the mapped operands.
  always @(negedge clk) begin
    if (fma_valid === 1'b1) begin
      chk("fma_valid_single_pulse", 32'(prev_fv), 32'd0);
      if (exp_fma_q.size() == 0) begin
        chk("unexpected_fma_valid", 32'(fma_valid), 32'd0);
      end else begin
        logic [95:0] e;
        e = exp_fma_q.pop_front();
        chk("fma_rs1", fma_rs1, e[95:64]);
        chk("fma_rs2", fma_rs2, e[63:32]);
        chk("fma_rs3", fma_rs3, e[31:0]);
      end
    end
    prev_fv = fma_valid;
  end

  // Offer one instruction in IDLE; returns in the first WAIT cycle.
  task automatic issue(input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] e1, input logic [31:0] e3);
    exp_fma_q.push_back({e1, 32'h40400000, e3});
    in_op = op; in_rs1 = 32'h40000000; in_rs2 = 32'h40400000; in_rs3 = 32'h3F800000;
    in_rd_idx = rd; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Wait n cycles, then pulse fma_done for one cycle with the given result.
  task automatic done(input int n, input logic [31:0] res);
    repeat (n) step();
    fma_done = 1'b1; fma_rd = res;
    step();
    fma_done = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] e1;
    logic [31:0] e3;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{op: 2'b00, e1: 32'h40000000, e3: 32'h3F800000, res: 32'h40E00000};
    vecs[1] = '{op: 2'b01, e1: 32'h40000000, e3: 32'hBF800000, res: 32'h40A00000};
    vecs[2] = '{op: 2'b10, e1: 32'hC0000000, e3: 32'h3F800000, res: 32'hC0A00000};
    vecs[3] = '{op: 2'b11, e1: 32'hC0000000, e3: 32'hBF800000, res: 32'hC0E00000};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    in_rd_idx = '0; flush = 1'b0; fma_done = 1'b0; fma_rd = '0; out_ready = 1'b1;
    step(); step();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_fma_valid", 32'(fma_valid), 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // All four ops with immediate writeback.
    for (int i = 0; i < 4; i++) begin
      exp_out_q.push_back({5'(5 + i), vecs[i].res});
      issue(vecs[i].op, 5'(5 + i), vecs[i].e1, vecs[i].e3);
      chk("wait_in_ready", 32'(in_ready), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      done(1, vecs[i].res);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("after_wb_out_valid", 32'(out_valid), 32'd0);
      chk("after_wb_in_ready", 32'(in_ready), 32'd1);
    end

    // Backpressure: result held stable, new instruction refused.
    out_ready = 1'b0;
    issue(2'b00, 5'd7, 32'h40000000, 32'h3F800000);
    done(2, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rd_idx = 5'd30;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_result", out_result, 32'h12345678);
      chk("bp_out_rd_idx", 32'(out_rd_idx), 32'd7);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    exp_out_q.push_back({5'd7, 32'h12345678});
    out_ready = 1'b1;
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_idle", 32'(busy), 32'd0);

    // Watchdog: no completion for 16 WAIT cycles.
    exp_out_q.push_back({5'd9, 32'h7FC00000});
    issue(2'b00, 5'd9, 32'h40000000, 32'h3F800000);
    repeat (15) step();
    chk("wd_still_waiting", 32'(out_valid), 32'd0);
    chk("wd_err_before", 32'(err), 32'd0);
    step();
    chk("wd_out_valid", 32'(out_valid), 32'd1);
    chk("wd_out_result", out_result, 32'h7FC00000);
    chk("wd_err", 32'(err), 32'd1);
    step(); step();
    chk("wd_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_clears_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Flush in 2nd WAIT cycle, orphan completion 3 cycles later.
    issue(2'b00, 5'd3, 32'h40000000, 32'h3F800000);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    done(2, 32'hDEADBEEF);
    chk("drain_back_idle", 32'(in_ready), 32'd1);
    chk("drain_err", 32'(err), 32'd0);
    exp_out_q.push_back({5'd4, 32'h40A00000});
    issue(2'b01, 5'd4, 32'h40000000, 32'hBF800000);
    done(3, 32'h40A00000);
    step();
    chk("post_flush_idle", 32'(busy), 32'd0);
    chk("post_flush_err", 32'(err), 32'd0);

    // Reset mid-WAIT, then a late completion is spurious.
    issue(2'b11, 5'd2, 32'hC0000000, 32'hBF800000);
    step();
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_fma_rs1", fma_rs1, 32'd0);
    chk("async_rst_out_rd_idx", 32'(out_rd_idx), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    done(0, 32'h11111111);
    chk("late_done_err", 32'(err), 32'd1);
    chk("late_done_out_valid", 32'(out_valid), 32'd0);
    chk("late_done_busy", 32'(busy), 32'd0);

    step(); step();
    chk("out_queue_drained", 32'(exp_out_q.size()), 32'd0);
    chk("fma_queue_drained", 32'(exp_fma_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
